// File: rtl/cpu_probe_scanner.sv
// Frame-based scanner that reads the CPU register file, data RAM and status ports and
// streams tagged 32-bit records on a valid/ready port. Optional checksum: PROBE_CHECKSUM_EN.
module cpu_probe_scanner #(
    parameter int          MEM_WORDS = 16,
    parameter logic [31:0] MEM_BASE  = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        frame_done,
    output logic [4:0]  rf_addr,
    input  logic [31:0] rf_data,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    input  logic [31:0] IF_pc,
    input  logic [31:0] IF_inst,
    input  logic [31:0] ID_pc,
    input  logic [31:0] EXE_pc,
    input  logic [31:0] MEM_pc,
    input  logic [31:0] WB_pc,
    input  logic [31:0] HI_data,
    input  logic [31:0] LO_data,
    input  logic [31:0] cpu_5_valid,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_tag,
    output logic [31:0] out_data
);

`ifdef PROBE_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_REG, S_MEM_ISSUE, S_MEM_CAP, S_STAT, S_CSUM, S_DONE
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_REG, S_MEM_ISSUE, S_MEM_CAP, S_STAT, S_DONE
    } state_t;
`endif

    localparam logic [5:0] MEM_LAST  = 6'(MEM_WORDS - 1);
    localparam logic [5:0] STAT_LAST = 6'd8;

    state_t      state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;
    logic [4:0]  rf_addr_q, rf_addr_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_tag_q, out_tag_d;
    logic [31:0] out_data_q, out_data_d;
    logic [31:0] shadow_q [9];
    logic [31:0] shadow_d [9];
`ifdef PROBE_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;
`endif

    logic        slot_free;
    logic        load;
    logic [7:0]  load_tag;
    logic [31:0] load_data;

    // The slot may be refilled in the same cycle its current record is accepted.
    assign slot_free = ~out_valid_q | out_ready;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d      = state_q;
        idx_d        = idx_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        rf_addr_d    = rf_addr_q;
        mem_addr_d   = mem_addr_q;
        out_valid_d  = out_valid_q & ~out_ready;
        out_tag_d    = out_tag_q;
        out_data_d   = out_data_q;
        shadow_d     = shadow_q;
`ifdef PROBE_CHECKSUM_EN
        csum_d       = csum_q;
`endif
        load      = 1'b0;
        load_tag  = 8'h00;
        load_data = 32'h0;

        case (state_q)
            S_IDLE: begin
                // frame_done_q high means this is the completion cycle; start is ignored there.
                if (start && !frame_done_q) begin
                    shadow_d = '{IF_pc, IF_inst, ID_pc, EXE_pc, MEM_pc, WB_pc,
                                 HI_data, LO_data, cpu_5_valid};
                    busy_d    = 1'b1;
                    rf_addr_d = 5'd0;
                    idx_d     = 6'd0;
`ifdef PROBE_CHECKSUM_EN
                    csum_d    = 32'h0;
`endif
                    state_d   = S_REG;
                end
            end
            S_REG: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_tag  = {3'b000, rf_addr_q};
                    load_data = rf_data;
                    if (rf_addr_q == 5'd31) begin
                        idx_d      = 6'd0;
                        mem_addr_d = MEM_BASE;
                        state_d    = S_MEM_ISSUE;
                    end else begin
                        rf_addr_d = rf_addr_q + 5'd1;
                    end
                end
            end
            S_MEM_ISSUE: begin
                state_d = S_MEM_CAP;
            end
            S_MEM_CAP: begin
                // mem_addr stays put while waiting, so the RAM keeps returning this word.
                if (slot_free) begin
                    load      = 1'b1;
                    load_tag  = {2'b01, idx_q};
                    load_data = mem_data;
                    if (idx_q == MEM_LAST) begin
                        idx_d   = 6'd0;
                        state_d = S_STAT;
                    end else begin
                        idx_d      = idx_q + 6'd1;
                        mem_addr_d = mem_addr_q + 32'd4;
                        state_d    = S_MEM_ISSUE;
                    end
                end
            end
            S_STAT: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_tag  = {4'b1000, idx_q[3:0]};
                    load_data = shadow_q[idx_q[3:0]];
                    if (idx_q == STAT_LAST) begin
`ifdef PROBE_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
`ifdef PROBE_CHECKSUM_EN
            S_CSUM: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_tag  = 8'hFF;
                    load_data = csum_q;
                    state_d   = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (slot_free) begin
                    frame_done_d = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load) begin
            out_valid_d = 1'b1;
            out_tag_d   = load_tag;
            out_data_d  = load_data;
`ifdef PROBE_CHECKSUM_EN
            csum_d      = csum_q ^ load_data;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            idx_q        <= 6'd0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            rf_addr_q    <= 5'd0;
            mem_addr_q   <= MEM_BASE;
            out_valid_q  <= 1'b0;
            out_tag_q    <= 8'h00;
            out_data_q   <= 32'h0;
            // NOTE: the shadow bank is only nine words, so it is reset like any other register.
            shadow_q     <= '{default: 32'h0};
`ifdef PROBE_CHECKSUM_EN
            csum_q       <= 32'h0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            idx_q        <= idx_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            rf_addr_q    <= rf_addr_d;
            mem_addr_q   <= mem_addr_d;
            out_valid_q  <= out_valid_d;
            out_tag_q    <= out_tag_d;
            out_data_q   <= out_data_d;
            shadow_q     <= shadow_d;
`ifdef PROBE_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign rf_addr    = rf_addr_q;
    assign mem_addr   = mem_addr_q;
    assign out_valid  = out_valid_q;
    assign out_tag    = out_tag_q;
    assign out_data   = out_data_q;

endmodule

// File: tb/tb_cpu_probe_scanner.sv
// Self-checking bench for cpu_probe_scanner: scenario table of frames against a
// bench-built expected record list, plus a hand-written mid-frame reset sequence.
module tb_cpu_probe_scanner;

    localparam int          MEM_WORDS = 16;
    localparam logic [31:0] MEM_BASE  = 32'h40;
`ifdef PROBE_CHECKSUM_EN
    localparam int N_REC = 32 + MEM_WORDS + 9 + 1;
`else
    localparam int N_REC = 32 + MEM_WORDS + 9;
`endif

    typedef struct packed {
        logic [7:0]  tag;
        logic [31:0] data;
    } rec_t;

    typedef struct {
        string name;
        int    ready_pct;
        bit    poke_if_pc;
        bit    start_glitch;
    } scen_t;

    logic        clk, reset, start, busy, frame_done;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data, mem_addr, mem_data;
    logic [31:0] IF_pc, IF_inst, ID_pc, EXE_pc, MEM_pc, WB_pc, HI_data, LO_data, cpu_5_valid;
    logic        out_valid, out_ready;
    logic [7:0]  out_tag;
    logic [31:0] out_data;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    done_cnt = 0;
    int    ready_pct = 100;
    rec_t  exp_rec [N_REC];
    rec_t  got_q [$];
    scen_t scen [4];
    logic [31:0] status_val [9];

    cpu_probe_scanner #(.MEM_WORDS(MEM_WORDS), .MEM_BASE(MEM_BASE)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .frame_done(frame_done),
        .rf_addr(rf_addr), .rf_data(rf_data), .mem_addr(mem_addr), .mem_data(mem_data),
        .IF_pc(IF_pc), .IF_inst(IF_inst), .ID_pc(ID_pc), .EXE_pc(EXE_pc), .MEM_pc(MEM_pc),
        .WB_pc(WB_pc), .HI_data(HI_data), .LO_data(LO_data), .cpu_5_valid(cpu_5_valid),
        .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag), .out_data(out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: rf[i] = i*3, combinational.
    assign rf_data = 32'(rf_addr) * 32'd3;

    // Sync RAM, 1-cycle latency: word at byte address a holds A000_0000 + a/4.
    always @(posedge clk) mem_data <= 32'hA000_0000 + {2'b00, mem_addr[31:2]};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    // Stream monitor: collects accepted records, checks hold-under-stall, counts frame_done.
    initial begin : monitor
        rec_t held;
        bit   hold;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                hold = 1'b0;
            end else begin
                if (hold)
                    check("stall_hold", 64'({out_valid, out_tag, out_data}), 64'({1'b1, held}));
                if (frame_done) done_cnt++;
                if (out_valid && out_ready) got_q.push_back({out_tag, out_data});
                hold = out_valid && !out_ready;
                held = {out_tag, out_data};
            end
        end
    end

    task automatic set_status();
        IF_pc = status_val[0]; IF_inst = status_val[1]; ID_pc = status_val[2];
        EXE_pc = status_val[3]; MEM_pc = status_val[4]; WB_pc = status_val[5];
        HI_data = status_val[6]; LO_data = status_val[7]; cpu_5_valid = status_val[8];
    endtask

    task automatic compare_frame(input string name);
        int n;
        check({name, "_count"}, 64'(got_q.size()), 64'(N_REC));
        n = (got_q.size() < N_REC) ? got_q.size() : N_REC;
        for (int k = 0; k < n; k++)
            check($sformatf("%s_rec%0d", name, k), 64'(got_q[k]), 64'(exp_rec[k]));
    endtask

    task automatic run_frame(input scen_t s);
        int cyc;
        bit seen;
        got_q.delete();
        done_cnt  = 0;
        ready_pct = s.ready_pct;
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        @(negedge clk);
        check({s.name, "_busy_start"}, 64'(busy), 64'(1));
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (s.poke_if_pc && cyc == 3) IF_pc = 32'hDEAD_BEEF;
            if (s.start_glitch && cyc == 20) start = 1'b1;
            if (s.start_glitch && cyc == 21) start = 1'b0;
            if (frame_done) begin
                seen = 1'b1;
                if (s.start_glitch) start = 1'b1;
            end
        end
        check({s.name, "_frame_done_seen"}, 64'(seen), 64'(1));
        @(posedge clk); #2 start = 1'b0;
        set_status();
        repeat (20) @(negedge clk);
        check({s.name, "_busy_after"}, 64'(busy), 64'(0));
        check({s.name, "_done_once"}, 64'(done_cnt), 64'(1));
        compare_frame(s.name);
    endtask

    initial begin : main
        int cyc;
        logic [31:0] x;

        status_val = '{32'h0000_1000, 32'h2402_0005, 32'h0000_0FFC, 32'h0000_0FF8,
                       32'h0000_0FF4, 32'h0000_0FF0, 32'h1111_2222, 32'h3333_4444,
                       32'h0000_001F};
        scen[0] = '{"full_rate",  100, 1'b0, 1'b0};
        scen[1] = '{"stall_poke",  50, 1'b1, 1'b0};
        scen[2] = '{"stall_glit",  50, 1'b0, 1'b1};
        scen[3] = '{"slow_both",   30, 1'b1, 1'b1};

        for (int i = 0; i < 32; i++)
            exp_rec[i] = {8'(i), 32'(i * 3)};
        for (int j = 0; j < MEM_WORDS; j++)
            exp_rec[32 + j] = {8'h40 | 8'(j), 32'hA000_0010 + 32'(j)};
        for (int s = 0; s < 9; s++)
            exp_rec[32 + MEM_WORDS + s] = {8'h80 + 8'(s), status_val[s]};
`ifdef PROBE_CHECKSUM_EN
        x = 32'h0;
        for (int k = 0; k < N_REC - 1; k++) x = x ^ exp_rec[k].data;
        exp_rec[N_REC - 1] = {8'hFF, x};
`else
        x = 32'h0;
`endif

        reset = 1'b1;
        start = 1'b0;
        out_ready = 1'b1;
        set_status();
        repeat (2) @(negedge clk);
        check("rst_busy",       64'(busy),       64'(0));
        check("rst_frame_done", 64'(frame_done), 64'(0));
        check("rst_out_valid",  64'(out_valid),  64'(0));
        check("rst_out_tag",    64'(out_tag),    64'(0));
        check("rst_out_data",   64'(out_data),   64'(0));
        check("rst_rf_addr",    64'(rf_addr),    64'(0));
        check("rst_mem_addr",   64'(mem_addr),   64'(MEM_BASE));
        @(posedge clk); #1 reset = 1'b0;

        for (int t = 0; t < 4; t++)
            run_frame(scen[t]);

        // Mid-frame reset right after reg 10 is accepted.
        got_q.delete();
        done_cnt  = 0;
        ready_pct = 100;
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        cyc = 0;
        while (got_q.size() < 11 && cyc < 500) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("abort_reached_reg10", 64'(got_q.size()), 64'(11));
        @(posedge clk); #1 reset = 1'b1;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'(0));
        check("abort_busy",      64'(busy),      64'(0));
        check("abort_out_tag",   64'(out_tag),   64'(0));
        @(posedge clk);
        @(posedge clk); #1 reset = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_no_frame_done", 64'(done_cnt), 64'(0));
        check("abort_busy_idle",     64'(busy),     64'(0));
        run_frame(scen[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
